// File: rtl/king_locator_pkg.sv
// Shared chess types and king-locator definitions.
// The multi-king check in king_locator is enabled by defining KING_LOC_MULTI_CHECK_EN.
package king_locator_pkg;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } color_t;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_t;

  typedef struct packed {
    color_t color;
    piece_t piece;
  } fullpiece_t;

  localparam int BOARD_SQUARES = 64;

  typedef enum logic [1:0] {
    KL_IDLE = 2'd0,
    KL_SCAN = 2'd1,
    KL_DONE = 2'd2
  } kingloc_state_t;

  function automatic logic is_king_of(input fullpiece_t p, input color_t side);
    return (p.piece == KING) && (p.color == side);
  endfunction

endpackage

// File: rtl/king_locator_match_group.sv
// Combinational king match over one scan group: hit flag, lowest hit offset, and >1 hit flag.
module king_match_group
  import king_locator_pkg::*;
#(
  parameter int N = 1
) (
  input  fullpiece_t  pieces [N],
  input  color_t      side,
  output logic        hit,
  output logic [2:0]  offset,
  output logic        multi
);

  logic m_s;

  // Walk from the top so the lowest matching offset is the last one written.
  always_comb begin
    hit    = 1'b0;
    offset = 3'd0;
    multi  = 1'b0;
    m_s    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      m_s    = is_king_of(pieces[k], side);
      multi  = multi | (m_s & hit);
      offset = m_s ? 3'(k) : offset;
      hit    = hit | m_s;
    end
  end

endmodule

// File: rtl/king_locator.sv
// Sequential king search, SQ_PER_CYCLE squares per clock, start/done handshake.
// Define KING_LOC_MULTI_CHECK_EN to force full scans and report duplicate kings.
module king_locator
  import king_locator_pkg::*;
#(
  parameter int SQ_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  color_t      side,
  input  fullpiece_t  board [BOARD_SQUARES],
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [5:0]  king_pos,
  output logic        multiple_kings
);

`ifdef KING_LOC_MULTI_CHECK_EN
  localparam bit MULTI_EN = 1'b1;
`else
  localparam bit MULTI_EN = 1'b0;
`endif

  localparam int LAST_IDX = BOARD_SQUARES - SQ_PER_CYCLE;

  generate
    if (!(SQ_PER_CYCLE == 1 || SQ_PER_CYCLE == 2 || SQ_PER_CYCLE == 4 || SQ_PER_CYCLE == 8)) begin : g_bad_sq
      $error("king_locator: SQ_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  kingloc_state_t state_r, next_s;
  logic [6:0]     idx_r;
  color_t         side_r;
  logic           found_r;
  logic [5:0]     pos_r;
  logic           multi_r;

  fullpiece_t     group_s [SQ_PER_CYCLE];
  logic           hit_s;
  logic [2:0]     off_s;
  logic           grp_multi_s;
  logic           accept_s;
  logic           last_group_s;

  // Busy is low in DONE, so a start arriving with the done pulse is taken.
  assign accept_s     = start && (state_r != KL_SCAN);
  assign last_group_s = (idx_r == 7'(LAST_IDX));

  // Select the group of squares under examination this cycle.
  always_comb begin
    for (int k = 0; k < SQ_PER_CYCLE; k++) begin
      group_s[k] = board[idx_r[5:0] + 6'(k)];
    end
  end

  king_match_group #(.N(SQ_PER_CYCLE)) u_match (
    .pieces (group_s),
    .side   (side_r),
    .hit    (hit_s),
    .offset (off_s),
    .multi  (grp_multi_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= KL_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = KL_IDLE;
    case (state_r)
      KL_IDLE: begin
        if (accept_s) next_s = KL_SCAN;
        else          next_s = KL_IDLE;
      end
      KL_SCAN: begin
        if (last_group_s || (hit_s && !MULTI_EN)) next_s = KL_DONE;
        else                                      next_s = KL_SCAN;
      end
      KL_DONE: begin
        if (accept_s) next_s = KL_SCAN;
        else          next_s = KL_IDLE;
      end
      default: next_s = KL_IDLE;
    endcase
  end

  // Scan index, latched side and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= 7'd0;
      side_r  <= WHITE;
      found_r <= 1'b0;
      pos_r   <= 6'd0;
      multi_r <= 1'b0;
    end else if (accept_s) begin
      idx_r   <= 7'd0;
      side_r  <= side;
      found_r <= 1'b0;
      pos_r   <= 6'd0;
      multi_r <= 1'b0;
    end else if (state_r == KL_SCAN) begin
      idx_r <= idx_r + 7'(SQ_PER_CYCLE);
      if (hit_s && !found_r) begin
        found_r <= 1'b1;
        pos_r   <= idx_r[5:0] + {3'b000, off_s};
      end else begin
        found_r <= found_r;
      end
      if (MULTI_EN && ((hit_s && found_r) || grp_multi_s)) begin
        multi_r <= 1'b1;
      end else begin
        multi_r <= multi_r;
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  // Output decode straight from registered state.
  always_comb begin
    busy           = (state_r == KL_SCAN);
    done           = (state_r == KL_DONE);
    found          = found_r;
    king_pos       = pos_r;
    multiple_kings = multi_r;
  end

endmodule

// File: tb/tb_king_locator.sv
// Directed self-checking bench for king_locator (SQ_PER_CYCLE=1 and 8 instances).
module tb_king_locator;
  import king_locator_pkg::*;

`ifdef KING_LOC_MULTI_CHECK_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start8;
  color_t      side;
  fullpiece_t  board [BOARD_SQUARES];
  logic        busy, done, found, multi;
  logic [5:0]  pos;
  logic        busy8, done8, found8, multi8;
  logic [5:0]  pos8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  king_locator #(.SQ_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .side(side), .board(board),
    .busy(busy), .done(done), .found(found), .king_pos(pos), .multiple_kings(multi)
  );

  king_locator #(.SQ_PER_CYCLE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .side(side), .board(board),
    .busy(busy8), .done(done8), .found(found8), .king_pos(pos8), .multiple_kings(multi8)
  );

  task automatic clear_board();
    for (int i = 0; i < BOARD_SQUARES; i++) board[i] = fullpiece_t'{color: WHITE, piece: EMPTY};
  endtask

  task automatic put_king(input int sq, input color_t c);
    board[sq] = fullpiece_t'{color: c, piece: KING};
  endtask

  // Pulses start at the current negedge; lat = cycles from accept to the done cycle.
  task automatic run_scan(input bit wide, output int lat, output int busy_cnt);
    logic d;
    lat = 0;
    busy_cnt = 0;
    if (wide) start8 = 1'b1; else start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    start8 = 1'b0;
    d = wide ? done8 : done;
    while (!d && lat < 200) begin
      if (wide ? busy8 : busy) busy_cnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
      d = wide ? done8 : done;
    end
    checks++;
    if (d !== 1'b1) begin
      failures++;
      $display("FAIL scan_timeout: done=%b after %0d cycles, required 1", d, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start8 = 1'b0;
    side = WHITE;
    clear_board();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, found, pos, multi} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b found=%b pos=%0d multi=%b, required all 0",
               busy, done, found, pos, multi);
    end
    checks++;
    if ({busy8, done8, found8, pos8, multi8} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs8: busy=%b done=%b found=%b pos=%0d multi=%b, required all 0",
               busy8, done8, found8, pos8, multi8);
    end
  endtask

  task automatic test_king_at_zero();
    int lat, bc;
    clear_board();
    put_king(0, WHITE);
    side = WHITE;
    run_scan(1'b0, lat, bc);
    checks++;
    if (lat !== (MULTI ? 65 : 2)) begin failures++; $display("FAIL k0_latency: got %0d required %0d", lat, MULTI ? 65 : 2); end
    checks++;
    if (found !== 1'b1 || pos !== 6'd0) begin failures++; $display("FAIL k0_result: found=%b pos=%0d required 1/0", found, pos); end
    checks++;
    if (bc !== (MULTI ? 64 : 1)) begin failures++; $display("FAIL k0_busy_cycles: got %0d required %0d", bc, MULTI ? 64 : 1); end
    checks++;
    if (multi !== 1'b0) begin failures++; $display("FAIL k0_multi: got %b required 0", multi); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || found !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL k0_after_done: done=%b found=%b busy=%b required 0/1/0", done, found, busy);
    end
  endtask

  task automatic test_black_king();
    int lat, bc;
    clear_board();
    put_king(4, WHITE);
    put_king(60, BLACK);
    side = BLACK;
    run_scan(1'b0, lat, bc);
    checks++;
    if (lat !== (MULTI ? 65 : 62)) begin failures++; $display("FAIL k60_latency: got %0d required %0d", lat, MULTI ? 65 : 62); end
    checks++;
    if (found !== 1'b1 || pos !== 6'd60) begin failures++; $display("FAIL k60_result: found=%b pos=%0d required 1/60", found, pos); end
    @(negedge clk);
  endtask

  task automatic test_no_king();
    int lat, bc;
    clear_board();
    put_king(5, BLACK);
    side = WHITE;
    run_scan(1'b0, lat, bc);
    checks++;
    if (lat !== 65) begin failures++; $display("FAIL nok_latency: got %0d required 65", lat); end
    checks++;
    if (found !== 1'b0 || pos !== 6'd0 || multi !== 1'b0) begin
      failures++;
      $display("FAIL nok_result: found=%b pos=%0d multi=%b required 0/0/0", found, pos, multi);
    end
    @(negedge clk);
  endtask

  task automatic test_wide_scan();
    int lat, bc;
    clear_board();
    put_king(63, BLACK);
    side = BLACK;
    run_scan(1'b1, lat, bc);
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL sq8_latency: got %0d required 9", lat); end
    checks++;
    if (found8 !== 1'b1 || pos8 !== 6'd63) begin failures++; $display("FAIL sq8_result: found=%b pos=%0d required 1/63", found8, pos8); end
    @(negedge clk);
  endtask

  task automatic test_robustness();
    int cyc;
    logic seen_done;
    clear_board();
    put_king(30, WHITE);
    side = WHITE;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (cyc == 5) begin start = 1'b1; side = BLACK; end
      else begin start = 1'b0; side = WHITE; end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    side = WHITE;
    checks++;
    if (cyc !== (MULTI ? 65 : 32)) begin failures++; $display("FAIL ignore_start_latency: got %0d required %0d", cyc, MULTI ? 65 : 32); end
    checks++;
    if (found !== 1'b1 || pos !== 6'd30) begin failures++; $display("FAIL ignore_start_result: found=%b pos=%0d required 1/30", found, pos); end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, found, pos, multi} !== 10'd0) begin
      failures++;
      $display("FAIL midscan_reset: busy=%b done=%b found=%b pos=%0d multi=%b, required all 0",
               busy, done, found, pos, multi);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    checks++;
    if (seen_done !== 1'b0) begin failures++; $display("FAIL midscan_reset_no_done: done seen=%b required 0", seen_done); end
  endtask

  task automatic test_two_kings();
    int lat, bc;
    clear_board();
    put_king(10, WHITE);
    put_king(20, WHITE);
    side = WHITE;
    run_scan(1'b0, lat, bc);
    checks++;
    if (lat !== (MULTI ? 65 : 12)) begin failures++; $display("FAIL two_latency: got %0d required %0d", lat, MULTI ? 65 : 12); end
    checks++;
    if (found !== 1'b1 || pos !== 6'd10) begin failures++; $display("FAIL two_result: found=%b pos=%0d required 1/10", found, pos); end
    checks++;
    if (multi !== MULTI) begin failures++; $display("FAIL two_multi: got %b required %b", multi, MULTI); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    clear_board();
    put_king(3, WHITE);
    side = WHITE;
    run_scan(1'b0, lat, bc);
    checks++;
    if (pos !== 6'd3 || lat !== (MULTI ? 65 : 5)) begin
      failures++;
      $display("FAIL b2b_first: pos=%0d lat=%0d required 3/%0d", pos, lat, MULTI ? 65 : 5);
    end
    clear_board();
    put_king(7, BLACK);
    side = BLACK;
    run_scan(1'b0, lat, bc);
    checks++;
    if (found !== 1'b1 || pos !== 6'd7 || lat !== (MULTI ? 65 : 9)) begin
      failures++;
      $display("FAIL b2b_second: found=%b pos=%0d lat=%0d required 1/7/%0d", found, pos, lat, MULTI ? 65 : 9);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_king_at_zero();
    test_black_king();
    test_no_king();
    test_wide_scan();
    test_robustness();
    test_two_kings();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
